// File: rtl/bec_la_loader_if.sv
// rtl/bec_la_loader_if.sv - core-side operand/result bus between LA loader and curve core
interface bec_la_loader_if #(
  parameter int OP_W  = 32,
  parameter int N_OPS = 4
);
  logic [N_OPS*OP_W-1:0] op_bus;
  logic                  core_start;
  logic                  core_done;
  logic [OP_W-1:0]       core_result;

  // loader side: drives operands and start, receives completion and result
  modport master (
    output op_bus,
    output core_start,
    input  core_done,
    input  core_result
  );

  // core side
  modport slave (
    input  op_bus,
    input  core_start,
    output core_done,
    output core_result
  );
endinterface

// File: rtl/bec_la_loader.sv
// rtl/bec_la_loader.sv - LA bit-serial operand loader and result readout for the curve core
module bec_la_loader #(
  parameter int OP_W  = 32,
  parameter int N_OPS = 4
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic [4:0]       la_in,
  output logic [31:0]      la_out,
  bec_la_loader_if.master  core_if
);
  localparam int TOTAL = N_OPS * OP_W;
  localparam int CNT_W = $clog2(TOTAL + 1);
  localparam int RD_W  = $clog2(OP_W + 1);
  localparam logic [CNT_W-1:0] TOTAL_C = CNT_W'(TOTAL);
  localparam logic [RD_W-1:0]  RD_LAST = RD_W'(OP_W - 1);
  localparam logic [RD_W-1:0]  RD_FULL = RD_W'(OP_W);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  logic [4:0]       la_s1_q, la_s2_q;
  logic [2:0]       edge_q;          // previous synchronized {start, load, sclk}
  state_t           state_q;
  logic [TOTAL-1:0] op_sr_q;
  logic [CNT_W-1:0] bit_cnt_q;
  logic [OP_W-1:0]  res_sr_q;
  logic [RD_W-1:0]  rd_cnt_q;
  logic             ready_q, ovf_q, short_q, rd_valid_q, sdo_q, core_start_q;

  logic             sdi, rd, sclk_re, load_re, load_fe, start_re;
  logic             full;
  logic [CNT_W-1:0] cnt_after;

  // two-flop synchronizer for the asynchronous LA pins, plus edge history
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      la_s1_q <= '0;
      la_s2_q <= '0;
      edge_q  <= '0;
    end else begin
      la_s1_q <= la_in;
      la_s2_q <= la_s1_q;
      edge_q  <= la_s2_q[3:1];
    end
  end

  // edge decode and the post-shift bit count used by the load-close check
  always_comb begin
    sdi       = la_s2_q[0];
    rd        = la_s2_q[4];
    sclk_re   = la_s2_q[1] & ~edge_q[0];
    load_re   = la_s2_q[2] & ~edge_q[1];
    load_fe   = ~la_s2_q[2] & edge_q[1];
    start_re  = la_s2_q[3] & ~edge_q[2];
    full      = (bit_cnt_q == TOTAL_C);
    cnt_after = (sclk_re && !full) ? bit_cnt_q + CNT_W'(1) : bit_cnt_q;
  end

  // control FSM with all registered outputs
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      state_q      <= S_IDLE;
      op_sr_q      <= '0;
      bit_cnt_q    <= '0;
      res_sr_q     <= '0;
      rd_cnt_q     <= '0;
      ready_q      <= 1'b0;
      ovf_q        <= 1'b0;
      short_q      <= 1'b0;
      rd_valid_q   <= 1'b0;
      sdo_q        <= 1'b0;
      core_start_q <= 1'b0;
    end else begin
      core_start_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (load_re) begin
            state_q   <= S_LOAD;
            bit_cnt_q <= '0;
            ready_q   <= 1'b0;
            ovf_q     <= 1'b0;
            short_q   <= 1'b0;
          end else if (start_re && ready_q) begin
            state_q      <= S_RUN;
            core_start_q <= 1'b1;
          end
        end
        S_LOAD: begin
          if (sclk_re) begin
            if (!full) begin
              op_sr_q   <= {op_sr_q[TOTAL-2:0], sdi};
              bit_cnt_q <= cnt_after;
            end else begin
              ovf_q <= 1'b1;
            end
          end
          if (load_fe) begin
            if (cnt_after == TOTAL_C) begin
              ready_q <= 1'b1;
            end else begin
              ready_q <= 1'b0;
              short_q <= 1'b1;
            end
            state_q <= S_IDLE;
          end
        end
        S_RUN: begin
          // a done coincident with our own start pulse cannot belong to this run
          if (core_if.core_done && !core_start_q) begin
            res_sr_q   <= core_if.core_result;
            sdo_q      <= core_if.core_result[OP_W-1];
            rd_cnt_q   <= '0;
            rd_valid_q <= 1'b1;
            state_q    <= S_DONE;
          end
        end
        S_DONE: begin
          if (load_re) begin
            rd_valid_q <= 1'b0;
            sdo_q      <= 1'b0;
            bit_cnt_q  <= '0;
            ready_q    <= 1'b0;
            ovf_q      <= 1'b0;
            short_q    <= 1'b0;
            state_q    <= S_LOAD;
          end else if (sclk_re && rd) begin
            res_sr_q <= {res_sr_q[OP_W-2:0], 1'b0};
            sdo_q    <= res_sr_q[OP_W-2];
            if (rd_cnt_q == RD_LAST) begin
              rd_cnt_q   <= RD_FULL;
              rd_valid_q <= 1'b0;
              ready_q    <= 1'b0;
              sdo_q      <= 1'b0;
              state_q    <= S_IDLE;
            end else begin
              rd_cnt_q <= rd_cnt_q + RD_W'(1);
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign core_if.op_bus     = op_sr_q;
  assign core_if.core_start = core_start_q;
  assign la_out = {24'd0, state_q, short_q, ovf_q, rd_valid_q,
                   (state_q == S_RUN), ready_q, sdo_q};
endmodule

// File: tb/tb_bec_la_loader.sv
// tb/tb_bec_la_loader.sv - self-checking scoreboard bench for bec_la_loader
module tb_bec_la_loader;
  localparam int OP_W  = 32;
  localparam int N_OPS = 4;
  localparam int TOTAL = OP_W * N_OPS;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sdi = 0, sclk = 0, load = 0, start = 0, rd = 0;
  logic [4:0]  la_in;
  logic [31:0] la_out;

  int checks = 0;
  int errors = 0;
  int start_cnt = 0;
  int core_delay = 50;
  logic [OP_W-1:0] core_res_val = 32'hCAFEF00D;
  int manual_req = 0;

  logic [TOTAL-1:0] exp_op_q[$];
  logic             exp_bit_q[$];

  bec_la_loader_if #(.OP_W(OP_W), .N_OPS(N_OPS)) bus ();

  bec_la_loader #(.OP_W(OP_W), .N_OPS(N_OPS)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst_n),
    .la_in    (la_in),
    .la_out   (la_out),
    .core_if  (bus.master)
  );

  assign la_in = {rd, start, load, sclk, sdi};

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic sclk_pulse(input logic b);
    sdi = b;
    wait_cyc(4);
    sclk = 1'b1;
    wait_cyc(4);
    sclk = 1'b0;
    wait_cyc(4);
  endtask

  task automatic load_bits(input logic [TOTAL-1:0] v, input int n);
    load = 1'b1;
    wait_cyc(4);
    for (int i = 0; i < n; i++) sclk_pulse((i < TOTAL) ? v[TOTAL-1-i] : 1'b1);
    load = 1'b0;
    wait_cyc(6);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    wait_cyc(4);
    start = 1'b0;
    wait_cyc(4);
  endtask

  task automatic wait_state(input string tag, input logic [1:0] s, input int max);
    int n = 0;
    while (la_out[7:6] !== s && n < max) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, la_out[7:6], s);
  endtask

  // core model: answers each core_start after core_delay cycles, or on manual request
  initial begin
    int seen = 0;
    bus.core_done = 1'b0;
    bus.core_result = '0;
    forever begin
      @(negedge clk);
      if (manual_req != seen) begin
        seen = manual_req;
        bus.core_done = 1'b1;
        bus.core_result = 32'h11112222;
        @(negedge clk);
        bus.core_done = 1'b0;
        bus.core_result = '0;
      end else if (bus.core_start === 1'b1) begin
        repeat (core_delay - 1) @(negedge clk);
        bus.core_done = 1'b1;
        bus.core_result = core_res_val;
        @(negedge clk);
        bus.core_done = 1'b0;
        bus.core_result = '0;
      end
    end
  end

  // start monitor: every start cycle must match a queued expectation
  always @(negedge clk) begin
    if (bus.core_start === 1'b1) begin
      start_cnt++;
      if (exp_op_q.size() > 0) check_eq("op_at_start", bus.op_bus, exp_op_q.pop_front());
      else check_eq("start_unexpected", bus.core_start, 1'b0);
    end
  end

  initial begin
    logic [TOTAL-1:0] p1, p2, p3, p4;
    logic [OP_W-1:0]  r;
    int sc;
    p1 = {32'h01234567, 32'h89ABCDEF, 32'hFEDCBA98, 32'h76543210};
    p2 = {32'hDEADBEEF, 32'h12345678, 32'hA5A5A5A5, 32'h00000001};
    p3 = {32'h5A5A0F0F, 32'hC3C3C3C3, 32'h80000000, 32'hFFFF0001};
    p4 = {32'h13579BDF, 32'h2468ACE0, 32'h0BADF00D, 32'h7FFFFFFE};

    wait_cyc(4);
    check_eq("rst_la_out", la_out, 32'd0);
    check_eq("rst_op_bus", bus.op_bus, '0);
    check_eq("rst_core_start", bus.core_start, 1'b0);
    rst_n = 1'b1;
    wait_cyc(4);

    // 1: reset in the middle of a load
    load = 1'b1;
    wait_cyc(4);
    for (int i = 0; i < 17; i++) sclk_pulse(p1[TOTAL-1-i]);
    rst_n = 1'b0;
    @(negedge clk);
    check_eq("midrst_state", la_out[7:6], 2'd0);
    check_eq("midrst_op_bus", bus.op_bus, '0);
    check_eq("midrst_la_out", la_out, 32'd0);
    load = 1'b0;
    wait_cyc(3);
    rst_n = 1'b1;
    wait_cyc(4);
    load_bits(p1, TOTAL);
    check_eq("t1_ready", la_out[1], 1'b1);
    check_eq("t1_op_bus", bus.op_bus, p1);
    check_eq("t1_errs", la_out[5:4], 2'b00);

    // 2: full operation, one start, busy until done
    load_bits(p2, TOTAL);
    check_eq("t2_op_bus", bus.op_bus, p2);
    core_delay = 50;
    core_res_val = 32'hCAFEF00D;
    sc = start_cnt;
    exp_op_q.push_back(p2);
    pulse_start();
    check_eq("t2_state_run", la_out[7:6], 2'd2);
    check_eq("t2_busy", la_out[2], 1'b1);
    wait_state("t2_done_state", 2'd3, 200);
    check_eq("t2_start_once", start_cnt, sc + 1);
    check_eq("t2_busy_off", la_out[2], 1'b0);
    check_eq("t2_rd_valid", la_out[3], 1'b1);

    // 3: serial readout of the result
    rd = 1'b1;
    r = core_res_val;
    for (int i = 0; i < OP_W; i++) exp_bit_q.push_back(r[OP_W-1-i]);
    for (int i = 0; i < OP_W; i++) begin
      check_eq("t3_sdo", la_out[0], exp_bit_q.pop_front());
      sclk_pulse(1'b0);
    end
    rd = 1'b0;
    check_eq("t3_rd_valid_off", la_out[3], 1'b0);
    check_eq("t3_state_idle", la_out[7:6], 2'd0);

    // 4: overflow load then short load
    load_bits(p3, TOTAL + 1);
    check_eq("t4_ovf", la_out[4], 1'b1);
    check_eq("t4_ovf_ready", la_out[1], 1'b1);
    check_eq("t4_op_bus", bus.op_bus, p3);
    load_bits(p4, 100);
    check_eq("t4_short", la_out[5], 1'b1);
    check_eq("t4_short_ready", la_out[1], 1'b0);
    sc = start_cnt;
    pulse_start();
    wait_cyc(60);
    check_eq("t4_no_start", start_cnt, sc);
    check_eq("t4_state", la_out[7:6], 2'd0);

    // 5: last sclk edge together with load falling edge
    load = 1'b1;
    wait_cyc(4);
    for (int i = 0; i < TOTAL - 1; i++) sclk_pulse(p4[TOTAL-1-i]);
    sdi = p4[0];
    wait_cyc(4);
    sclk = 1'b1;
    load = 1'b0;
    wait_cyc(4);
    sclk = 1'b0;
    wait_cyc(6);
    check_eq("t5_ready", la_out[1], 1'b1);
    check_eq("t5_short", la_out[5], 1'b0);
    check_eq("t5_op_bus", bus.op_bus, p4);
    manual_req++;
    wait_cyc(10);
    check_eq("t5_idle_done_state", la_out[7:6], 2'd0);
    check_eq("t5_idle_done_rdv", la_out[3], 1'b0);

    // 6: pin activity during RUN is ignored; load aborts readout
    core_delay = 300;
    core_res_val = 32'h0F1E2D3C;
    sc = start_cnt;
    exp_op_q.push_back(p4);
    pulse_start();
    check_eq("t6_run", la_out[7:6], 2'd2);
    load = 1'b1;
    wait_cyc(4);
    load = 1'b0;
    wait_cyc(4);
    pulse_start();
    for (int i = 0; i < 3; i++) sclk_pulse(1'b1);
    check_eq("t6_op_bus_stable", bus.op_bus, p4);
    check_eq("t6_still_run", la_out[7:6], 2'd2);
    wait_state("t6_done_state", 2'd3, 400);
    check_eq("t6_start_once", start_cnt, sc + 1);
    rd = 1'b1;
    r = core_res_val;
    for (int i = 0; i < 10; i++) exp_bit_q.push_back(r[OP_W-1-i]);
    for (int i = 0; i < 10; i++) begin
      check_eq("t6_sdo", la_out[0], exp_bit_q.pop_front());
      sclk_pulse(1'b0);
    end
    rd = 1'b0;
    load = 1'b1;
    wait_cyc(6);
    check_eq("t6_abort_state", la_out[7:6], 2'd1);
    check_eq("t6_abort_rdv", la_out[3], 1'b0);
    load = 1'b0;
    wait_cyc(6);
    check_eq("sb_empty", exp_op_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/bec_la_loader.md
Name: bec_la_loader

Overview:
- Logic-analyzer front end for the binary-Edwards-curve core.
- Receives the 5 LA control/data bits routed from la_data_in[36:32], bit-serially loads N_OPS operands, and pulses start into the core.
- Captures the core result and shifts it back out bit-serially on an LA output.
- Sits directly upstream and downstream of the core datapath inside user_proj_example.

Parameters:
OP_W, 32, width of each operand and of the result in bits
N_OPS, 4, number of operands loaded per operation (TOTAL = N_OPS*OP_W)

Ports:
wb_clk_i  input  1  single system clock
wb_rst_i  input  1  reset, asynchronous assert, active-low
la_in  input  5  [0] sdi, [1] sclk, [2] load, [3] start, [4] rd; asynchronous to wb_clk_i
op_bus  output  N_OPS*OP_W  operand vector to core; operand 0 in the MSBs
core_start  output  1  one-cycle start pulse to core
core_done  input  1  core completion strobe, synchronous to wb_clk_i
core_result  input  OP_W  core result, valid while core_done=1
la_out  output  32  [0] sdo, [1] ready, [2] busy, [3] rd_valid, [4] ovf_err, [5] short_err, [7:6] state, [31:8] zero

Behaviour:
- Reset (wb_rst_i=0, async): all registers 0. State=IDLE; op_bus=0; core_start=0; la_out=0. Applies mid-operation too, with no pending start or shift.
- Every la_in bit passes through a 2-FF synchronizer.
- sclk_re, load_re, load_fe and start_re are single-cycle edge detects on the synchronized bits.
- Pin-to-action latency is 3 wb_clk_i cycles.
- State encoding: IDLE=0, LOAD=1, RUN=2, DONE=3.
- IDLE:
  - load_re -> LOAD. Clear bit_cnt, ready, ovf_err and short_err.
  - start_re with ready=1 -> RUN. core_start=1 for exactly one cycle, on the cycle after start_re.
  - start_re with ready=0 is ignored.
- LOAD:
  - On sclk_re: op_sr <= {op_sr[TOTAL-2:0], sdi}, so the first bit ends in the MSB.
  - bit_cnt increments and saturates at TOTAL.
  - sclk_re when bit_cnt==TOTAL: bit discarded, ovf_err=1.
  - On load_fe: bit_cnt==TOTAL -> ready=1; otherwise short_err=1 and ready=0. Then -> IDLE.
  - sclk_re and load_fe in the same cycle: the shift is applied first, and the count check uses the updated bit_cnt.
- op_bus = op_sr continuously. op_sr changes only in LOAD, so it is stable throughout RUN.
- RUN:
  - busy=1.
  - la_load and la_start edges are ignored.
  - On core_done: res_sr <= core_result; rd_cnt=0; rd_valid=1; -> DONE.
  - No timeout.
- core_done outside RUN is ignored, including core_done in the cycle core_start is asserted.
- DONE:
  - sdo = res_sr[OP_W-1], registered.
  - On sclk_re with rd=1: res_sr shifts left with 0 fill, and rd_cnt increments.
  - When rd_cnt reaches OP_W: rd_valid=0 and ready=0 -> IDLE.
  - load_re in DONE aborts readout: rd_valid=0, and the block enters LOAD with the same clears as from IDLE.
- la_out[7:6] mirrors the state register. busy=1 only in RUN.
- All outputs are registered. There are no combinational paths from la_in or core_* to outputs.

Test Plan:
1. Reset mid-LOAD after 17 bits -> next cycle state=0, op_bus=0, la_out=0. After release, a fresh load of 128 bits sets ready=1.
2. Load operands 0xDEADBEEF, 0x12345678, 0xA5A5A5A5, 0x00000001 MSB-first, then pulse start:
   - op_bus=0xDEADBEEF12345678A5A5A5A500000001.
   - Exactly one core_start cycle.
   - busy=1 until core_done.
3. Core model returns 0xCAFEF00D after 50 cycles; assert rd with 32 sclk pulses -> sdo sequence equals 0xCAFEF00D MSB first, then rd_valid=0 and state=IDLE.
4. Load 129 bits -> ovf_err=1, ready=1, op_bus holds the first 128 bits. Load 100 bits -> short_err=1, ready=0, and a following start pulse produces no core_start.
5. Last sclk edge coincident with load falling edge at bit 128 -> ready=1. core_done pulsed while in IDLE -> no state change.
6. During RUN, toggle load, start and sclk -> op_bus unchanged and no extra core_start. In DONE after 10 bits read, a load_re enters LOAD with rd_valid=0.
